// File: rtl/nic_host_pkg.sv
// Shared constants for the NIC host controller: FSM state codes, NIC register map
// and the position of the "full" flag in the NIC status registers.
package nic_host_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_POLL_OUT  = 3'd1;
    localparam logic [2:0] ST_WRITE_OUT = 3'd2;
    localparam logic [2:0] ST_POLL_IN   = 3'd3;
    localparam logic [2:0] ST_READ_IN   = 3'd4;

    localparam logic [1:0] ADDR_IN_BUF     = 2'b00;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF    = 2'b10;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

    localparam int STATUS_FULL_BIT = 0;

endpackage

// File: rtl/nic_host_ctrl_if.sv
// Host-side packet handshakes and the NIC register bus, bundled for nic_host_ctrl.
// slave = the controller's view, master = the host/NIC environment's view.
interface nic_host_ctrl_if #(
    parameter int PACKET_WIDTH = 64
);
    logic                    tx_valid;
    logic [PACKET_WIDTH-1:0] tx_data;
    logic                    tx_ready;
    logic                    rx_valid;
    logic [PACKET_WIDTH-1:0] rx_data;
    logic                    rx_ready;
    logic [1:0]              nic_addr;
    logic [PACKET_WIDTH-1:0] nic_d_in;
    logic [PACKET_WIDTH-1:0] nic_d_out;
    logic                    nic_en;
    logic                    nic_en_wr;

    modport slave (
        input  tx_valid, tx_data, rx_ready, nic_d_out,
        output tx_ready, rx_valid, rx_data, nic_addr, nic_d_in, nic_en, nic_en_wr
    );

    modport master (
        output tx_valid, tx_data, rx_ready, nic_d_out,
        input  tx_ready, rx_valid, rx_data, nic_addr, nic_d_in, nic_en, nic_en_wr
    );
endinterface

// File: rtl/nic_host_ctrl_sat_counter.sv
// 16-bit incrementer that sticks at 16'hFFFF instead of wrapping; used by the
// optional statistics counters of nic_host_ctrl.
module sat_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);
    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/nic_host_ctrl.sv
// Moves host tx packets into the NIC output buffer and NIC input buffer packets into a
// single-entry rx slot. Define NIC_HOST_CTRL_STATS_EN to add tx/rx/busy counters.
module nic_host_ctrl
    import nic_host_pkg::*;
#(
    parameter int PACKET_WIDTH = 64
) (
    input  logic clk,
    input  logic reset,
    nic_host_ctrl_if.slave bus
`ifdef NIC_HOST_CTRL_STATS_EN
    ,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
    output logic [15:0] busy_count
`endif
);
    logic [2:0]              state_q, state_d;
    logic                    rr_rx_q, rr_rx_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [PACKET_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                    tx_cand;
    logic                    rx_cand;
    logic                    status_full;

    assign tx_cand     = bus.tx_valid;
    assign rx_cand     = !rx_valid_q;
    assign status_full = bus.nic_d_out[STATUS_FULL_BIT];

    // rr_rx_q set means RX wins the next tie; it flips toward whichever side was not just served.
    always_comb begin
        state_d = state_q;
        rr_rx_d = rr_rx_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_cand && (!rx_cand || !rr_rx_q)) begin
                    state_d = ST_POLL_OUT;
                    rr_rx_d = 1'b1;
                end else if (rx_cand) begin
                    state_d = ST_POLL_IN;
                    rr_rx_d = 1'b0;
                end
            end
            ST_POLL_OUT:  state_d = (!status_full && bus.tx_valid) ? ST_WRITE_OUT : ST_IDLE;
            ST_WRITE_OUT: state_d = ST_IDLE;
            ST_POLL_IN:   state_d = status_full ? ST_READ_IN : ST_IDLE;
            ST_READ_IN:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (state_q == ST_READ_IN) begin
            rx_valid_d = 1'b1;
            rx_data_d  = bus.nic_d_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_rx_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_rx_q    <= rr_rx_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // NIC bus is decoded from the state register alone, so reset drops it asynchronously.
    always_comb begin
        bus.nic_en    = 1'b0;
        bus.nic_en_wr = 1'b0;
        bus.nic_addr  = 2'b00;
        bus.nic_d_in  = '0;
        bus.tx_ready  = 1'b0;
        case (state_q)
            ST_POLL_OUT: begin
                bus.nic_en   = 1'b1;
                bus.nic_addr = ADDR_OUT_STATUS;
            end
            ST_WRITE_OUT: begin
                bus.nic_en    = 1'b1;
                bus.nic_en_wr = 1'b1;
                bus.nic_addr  = ADDR_OUT_BUF;
                bus.nic_d_in  = bus.tx_data;
                bus.tx_ready  = 1'b1;
            end
            ST_POLL_IN: begin
                bus.nic_en   = 1'b1;
                bus.nic_addr = ADDR_IN_STATUS;
            end
            ST_READ_IN: begin
                bus.nic_en   = 1'b1;
                bus.nic_addr = ADDR_IN_BUF;
            end
            default: begin
                bus.nic_en = 1'b0;
            end
        endcase
    end

    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;

`ifdef NIC_HOST_CTRL_STATS_EN
    sat_counter u_tx_count (
        .clk   (clk),
        .reset (reset),
        .inc   (state_q == ST_WRITE_OUT),
        .count (tx_count)
    );

    sat_counter u_rx_count (
        .clk   (clk),
        .reset (reset),
        .inc   (state_q == ST_READ_IN),
        .count (rx_count)
    );

    sat_counter u_busy_count (
        .clk   (clk),
        .reset (reset),
        .inc   ((state_q == ST_POLL_OUT) && status_full),
        .count (busy_count)
    );
`endif
endmodule

// File: tb/tb_nic_host_ctrl.sv
// Directed bench for nic_host_ctrl: a cycle-by-cycle vector table plus hand-written
// sequences for busy polling, reset mid-write and (with NIC_HOST_CTRL_STATS_EN) counters.
module tb_nic_host_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_full = 1'b0;
    logic out_full = 1'b0;
    logic [63:0] in_buf = 64'd0;
    int checks = 0;
    int failures = 0;

    nic_host_ctrl_if #(.PACKET_WIDTH(64)) bus ();

`ifdef NIC_HOST_CTRL_STATS_EN
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic [15:0] busy_count;
`endif

    nic_host_ctrl #(.PACKET_WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef NIC_HOST_CTRL_STATS_EN
        ,
        .tx_count   (tx_count),
        .rx_count   (rx_count),
        .busy_count (busy_count)
`endif
    );

    always #5 clk = ~clk;

    // Combinational NIC register file model driven by the bench's status/buffer variables.
    always_comb begin
        case (bus.nic_addr)
            2'b00:   bus.nic_d_out = in_buf;
            2'b01:   bus.nic_d_out = {63'd0, in_full};
            2'b11:   bus.nic_d_out = {63'd0, out_full};
            default: bus.nic_d_out = 64'd0;
        endcase
    end

    typedef struct {
        logic        tx_valid;
        logic [63:0] tx_data;
        logic        rx_ready;
        logic        in_full;
        logic        out_full;
        logic [63:0] in_buf;
        logic        exp_en;
        logic        exp_wr;
        logic [1:0]  exp_addr;
        logic [63:0] exp_d_in;
        logic        exp_tx_ready;
        logic        exp_rx_valid;
        logic [63:0] exp_rx_data;
    } vec_t;

    vec_t vecs[20];

    task automatic applyStimulus(input vec_t v);
        bus.tx_valid = v.tx_valid;
        bus.tx_data  = v.tx_data;
        bus.rx_ready = v.rx_ready;
        in_full      = v.in_full;
        out_full     = v.out_full;
        in_buf       = v.in_buf;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_en"}, 64'(bus.nic_en), 64'd0);
        checkOutput({tag, "_wr"}, 64'(bus.nic_en_wr), 64'd0);
        checkOutput({tag, "_addr"}, 64'(bus.nic_addr), 64'd0);
        checkOutput({tag, "_d_in"}, bus.nic_d_in, 64'd0);
        checkOutput({tag, "_tx_ready"}, 64'(bus.tx_ready), 64'd0);
        checkOutput({tag, "_rx_valid"}, 64'(bus.rx_valid), 64'd0);
        checkOutput({tag, "_rx_data"}, bus.rx_data, 64'd0);
    endtask

    initial begin
        int polls;
        int writes;
        int early;
        bit found;

        // Inputs: tx_valid, tx_data, rx_ready, in_full, out_full, in_buf |
        // expected: en, wr, addr, d_in, tx_ready, rx_valid, rx_data
        vecs[0]  = '{1'b1, 64'hA5A5,     1'b0, 1'b0, 1'b0, 64'd0,    1'b0, 1'b0, 2'd0, 64'd0,        1'b0, 1'b0, 64'd0};
        vecs[1]  = '{1'b1, 64'hA5A5,     1'b0, 1'b0, 1'b0, 64'd0,    1'b1, 1'b0, 2'd3, 64'd0,        1'b0, 1'b0, 64'd0};
        vecs[2]  = '{1'b1, 64'hA5A5,     1'b0, 1'b0, 1'b0, 64'd0,    1'b1, 1'b1, 2'd2, 64'hA5A5,     1'b1, 1'b0, 64'd0};
        vecs[3]  = '{1'b0, 64'd0,        1'b0, 1'b0, 1'b0, 64'd0,    1'b0, 1'b0, 2'd0, 64'd0,        1'b0, 1'b0, 64'd0};
        vecs[4]  = '{1'b0, 64'd0,        1'b0, 1'b1, 1'b0, 64'h1234, 1'b1, 1'b0, 2'd1, 64'd0,        1'b0, 1'b0, 64'd0};
        vecs[5]  = '{1'b0, 64'd0,        1'b0, 1'b1, 1'b0, 64'h1234, 1'b1, 1'b0, 2'd0, 64'd0,        1'b0, 1'b0, 64'd0};
        vecs[6]  = '{1'b0, 64'd0,        1'b0, 1'b1, 1'b0, 64'd0,    1'b0, 1'b0, 2'd0, 64'd0,        1'b0, 1'b1, 64'h1234};
        vecs[7]  = '{1'b0, 64'd0,        1'b0, 1'b1, 1'b0, 64'd0,    1'b0, 1'b0, 2'd0, 64'd0,        1'b0, 1'b1, 64'h1234};
        vecs[8]  = '{1'b0, 64'd0,        1'b1, 1'b0, 1'b0, 64'd0,    1'b0, 1'b0, 2'd0, 64'd0,        1'b0, 1'b1, 64'h1234};
        vecs[9]  = '{1'b1, 64'hDEADBEEF, 1'b0, 1'b0, 1'b0, 64'd0,    1'b0, 1'b0, 2'd0, 64'd0,        1'b0, 1'b0, 64'h1234};
        vecs[10] = '{1'b1, 64'hDEADBEEF, 1'b0, 1'b0, 1'b1, 64'd0,    1'b1, 1'b0, 2'd3, 64'd0,        1'b0, 1'b0, 64'h1234};
        vecs[11] = '{1'b1, 64'hDEADBEEF, 1'b0, 1'b0, 1'b0, 64'd0,    1'b0, 1'b0, 2'd0, 64'd0,        1'b0, 1'b0, 64'h1234};
        vecs[12] = '{1'b1, 64'hDEADBEEF, 1'b0, 1'b0, 1'b0, 64'd0,    1'b1, 1'b0, 2'd1, 64'd0,        1'b0, 1'b0, 64'h1234};
        vecs[13] = '{1'b1, 64'hDEADBEEF, 1'b0, 1'b0, 1'b0, 64'd0,    1'b0, 1'b0, 2'd0, 64'd0,        1'b0, 1'b0, 64'h1234};
        vecs[14] = '{1'b1, 64'hDEADBEEF, 1'b0, 1'b0, 1'b0, 64'd0,    1'b1, 1'b0, 2'd3, 64'd0,        1'b0, 1'b0, 64'h1234};
        vecs[15] = '{1'b1, 64'hDEADBEEF, 1'b0, 1'b0, 1'b0, 64'd0,    1'b1, 1'b1, 2'd2, 64'hDEADBEEF, 1'b1, 1'b0, 64'h1234};
        vecs[16] = '{1'b0, 64'd0,        1'b0, 1'b1, 1'b0, 64'd0,    1'b0, 1'b0, 2'd0, 64'd0,        1'b0, 1'b0, 64'h1234};
        vecs[17] = '{1'b0, 64'd0,        1'b0, 1'b1, 1'b0, 64'h5678, 1'b1, 1'b0, 2'd1, 64'd0,        1'b0, 1'b0, 64'h1234};
        vecs[18] = '{1'b0, 64'd0,        1'b0, 1'b0, 1'b0, 64'h5678, 1'b1, 1'b0, 2'd0, 64'd0,        1'b0, 1'b0, 64'h1234};
        vecs[19] = '{1'b0, 64'd0,        1'b0, 1'b0, 1'b0, 64'd0,    1'b0, 1'b0, 2'd0, 64'd0,        1'b0, 1'b1, 64'h5678};

        bus.tx_valid = 1'b0;
        bus.tx_data  = 64'd0;
        bus.rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            if (i == 0) reset = 1'b0;
            #1;
            checkOutput($sformatf("v%0d_en", i), 64'(bus.nic_en), 64'(vecs[i].exp_en));
            checkOutput($sformatf("v%0d_wr", i), 64'(bus.nic_en_wr), 64'(vecs[i].exp_wr));
            checkOutput($sformatf("v%0d_addr", i), 64'(bus.nic_addr), 64'(vecs[i].exp_addr));
            checkOutput($sformatf("v%0d_d_in", i), bus.nic_d_in, vecs[i].exp_d_in);
            checkOutput($sformatf("v%0d_tx_ready", i), 64'(bus.tx_ready), 64'(vecs[i].exp_tx_ready));
            checkOutput($sformatf("v%0d_rx_valid", i), 64'(bus.rx_valid), 64'(vecs[i].exp_rx_valid));
            checkOutput($sformatf("v%0d_rx_data", i), bus.rx_data, vecs[i].exp_rx_data);
        end

        // Reset in the middle of WRITE_OUT: bus must drop at once and the held rx packet is lost.
        bus.tx_valid = 1'b1;
        bus.tx_data  = 64'hCAFE;
        out_full     = 1'b0;
        found        = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            #1;
            if (bus.nic_en_wr) found = 1'b1;
        end
        checkOutput("mid_reset_write_reached", 64'(found), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_en", 64'(bus.nic_en), 64'd0);
        checkOutput("mid_reset_tx_ready", 64'(bus.tx_ready), 64'd0);
        checkOutput("mid_reset_rx_valid", 64'(bus.rx_valid), 64'd0);
        checkOutput("mid_reset_rx_data", bus.rx_data, 64'd0);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_idle_en", 64'(bus.nic_en), 64'd0);
        checkOutput("post_reset_tx_ready", 64'(bus.tx_ready), 64'd0);

        // Output buffer busy for five polls, then a single write.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        in_full      = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 64'hBEEF;
        polls  = 0;
        writes = 0;
        early  = 0;
        for (int c = 0; c < 60 && writes == 0; c++) begin
            @(negedge clk);
            out_full = (polls < 5);
            #1;
            if (bus.nic_en && !bus.nic_en_wr && bus.nic_addr == 2'd3) polls++;
            if (bus.tx_ready) begin
                writes++;
                if (polls < 6) early++;
                checkOutput("busy_write_d_in", bus.nic_d_in, 64'hBEEF);
            end
        end
        @(negedge clk);
        bus.tx_valid = 1'b0;
        checkOutput("busy_polls", 64'(polls), 64'd6);
        checkOutput("busy_writes", 64'(writes), 64'd1);
        checkOutput("busy_early_ready", 64'(early), 64'd0);
`ifdef NIC_HOST_CTRL_STATS_EN
        checkOutput("busy_count", 64'(busy_count), 64'd5);
        checkOutput("busy_tx_count", 64'(tx_count), 64'd1);
        checkOutput("busy_rx_count", 64'(rx_count), 64'd0);

        // Preload tx_count just below saturation and push three more writes through.
        force dut.u_tx_count.count_q = 16'hFFFE;
        #1;
        release dut.u_tx_count.count_q;
        out_full     = 1'b0;
        bus.tx_valid = 1'b1;
        writes = 0;
        for (int c = 0; c < 60 && writes < 3; c++) begin
            @(negedge clk);
            #1;
            if (bus.tx_ready) writes++;
        end
        @(negedge clk);
        bus.tx_valid = 1'b0;
        checkOutput("sat_writes", 64'(writes), 64'd3);
        checkOutput("sat_tx_count", 64'(tx_count), 64'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nic_host_ctrl.md
NIC_HOST_CTRL -- requirements
Module: nic_host_ctrl

Interface
REQ-001 SHALL have parameter: PACKET_WIDTH, 64, width of tx/rx packets and NIC data buses.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: tx_valid  in  1  host has a packet to send.
REQ-005 SHALL have port: tx_data  in  PACKET_WIDTH  packet to send; stable while tx_valid && !tx_ready.
REQ-006 SHALL have port: tx_ready  out  1  one-cycle pulse; tx_data consumed this cycle.
REQ-007 SHALL have port: rx_valid  out  1  received packet held in rx_data.
REQ-008 SHALL have port: rx_data  out  PACKET_WIDTH  received packet.
REQ-009 SHALL have port: rx_ready  in  1  host accepts rx_data.
REQ-010 SHALL have port: nic_addr  out  2  NIC register select.
REQ-011 SHALL have port: nic_d_in  out  PACKET_WIDTH  write data to NIC.
REQ-012 SHALL have port: nic_d_out  in  PACKET_WIDTH  combinational read data from NIC.
REQ-013 SHALL have port: nic_en  out  1  NIC access enable.
REQ-014 SHALL have port: nic_en_wr  out  1  1 = write, 0 = read.

Function
REQ-015 SHALL use the NIC map: 2'b00 input buffer (read), 2'b01 input status (read), 2'b10 output buffer (write), 2'b11 output status (read); status bit 0 = 1 means full.
REQ-016 SHALL implement FSM states IDLE, POLL_OUT, WRITE_OUT, POLL_IN, READ_IN; each state lasts exactly one cycle.
REQ-017 IDLE: nic_en=0; tx candidate = tx_valid; rx candidate = !rx_valid.
REQ-018 IDLE: if one candidate, go to its poll state; if both, go to the state not chosen last (1-bit round-robin flag, reset to favour TX); if none, stay in IDLE.
REQ-019 POLL_OUT: nic_en=1, nic_en_wr=0, nic_addr=2'b11; nic_d_out[0]==0 -> WRITE_OUT, else -> IDLE.
REQ-020 WRITE_OUT: nic_en=1, nic_en_wr=1, nic_addr=2'b10, nic_d_in=tx_data, tx_ready=1; -> IDLE.
REQ-021 POLL_IN: nic_en=1, nic_en_wr=0, nic_addr=2'b01; nic_d_out[0]==1 -> READ_IN, else -> IDLE.
REQ-022 READ_IN: nic_en=1, nic_en_wr=0, nic_addr=2'b00; at the edge, capture nic_d_out into rx_data and set rx_valid; -> IDLE.
REQ-023 The round-robin flag SHALL update on every exit from IDLE to a poll state.
REQ-024 rx_valid SHALL clear on the edge where rx_valid && rx_ready; rx_data SHALL hold until then.
REQ-025 POLL_IN SHALL never be entered while rx_valid=1, so the single rx slot cannot overflow.
REQ-026 nic_d_in SHALL be 0 outside WRITE_OUT; nic_addr SHALL be 0 when nic_en=0.
REQ-027 Minimum latency: tx_valid seen in IDLE -> tx_ready 2 cycles later; input status full seen in POLL_IN -> rx_valid 2 edges later.
REQ-028 tx_ready SHALL never assert without tx_valid.

Reset
REQ-029 Reset SHALL force IDLE with round-robin flag = TX and all outputs 0 (tx_ready, rx_valid, rx_data, nic_addr, nic_d_in, nic_en, nic_en_wr).
REQ-030 Reset mid-transfer SHALL abort immediately (nic_en drops asynchronously) and discard any held rx packet.

Configuration
REQ-031 Macro NIC_HOST_CTRL_STATS_EN defined: adds outputs tx_count[15:0], rx_count[15:0], and busy_count[15:0]; each saturates at 16'hFFFF and resets to 0.
REQ-032 tx_count increments on WRITE_OUT, rx_count on READ_IN, and busy_count on POLL_OUT exits with the output buffer full.
REQ-033 Macro undefined: these ports and counters do not exist; all other behaviour is identical.

Structure
REQ-034 Package nic_host_pkg SHALL hold the FSM state enum, the four NIC address constants, and STATUS_FULL_BIT=0.
REQ-035 One sub-module, sat_counter (16-bit saturating incrementer), SHALL be used for the statistics counters only.

Verification
REQ-036 Verify: reset, then tx_valid=1, tx_data=64'hA5A5, output status 0 -> POLL_OUT (addr 3) then WRITE_OUT (addr 2, d_in A5A5, tx_ready=1) in consecutive cycles.
REQ-037 Verify: output status held full for 5 polls, then clear -> 5 POLL_OUT->IDLE loops with tx_ready=0, then one write; busy_count=5 when STATS_EN is defined.
REQ-038 Verify: input status full, input buffer 64'h1234, rx_ready=0 -> rx_valid=1, rx_data=1234, and no further POLL_IN until rx_ready=1.
REQ-039 Verify: tx_valid=1 and rx slot empty together -> poll order from IDLE alternates TX, RX, TX.
REQ-040 Verify: reset asserted during WRITE_OUT -> nic_en=0 before the next edge, no tx_ready, FSM in IDLE after release.
REQ-041 Verify: with STATS_EN defined and tx_count preloaded near 16'hFFFF, further writes hold tx_count at 16'hFFFF.
